// File: rtl/video_in_pkg.sv
`default_nettype none
// video_in_pkg: shared state encoding, frame constants and Wishbone CTI codes for video_in_store. Rev 1.0
package video_in_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    FEND  = 2'd3
  } state_e;

  localparam int WORDS  = 640 * 480 / 4;
  localparam int BURSTS = WORDS / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  function automatic logic [31:0] pick_base(input logic sel, input logic [31:0] b0,
                                            input logic [31:0] b1);
    return sel ? b1 : b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_in_store.sv
`default_nettype none
// video_in_store: drains the 4-pixel-per-word capture FIFO into fixed-length Wishbone
// incrementing bursts, ping-ponging between two frame buffers. Rev 1.0
module video_in_store
  import video_in_pkg::*;
#(
  parameter int p_WIDTH   = 640,
  parameter int p_HEIGHT  = 480,
  parameter int p_BURST   = 8,
  parameter int p_LEVEL_W = 6
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 enable,
  input  logic [31:0]          base_addr0,
  input  logic [31:0]          base_addr1,
  input  logic [31:0]          fifo_data,
  input  logic [p_LEVEL_W-1:0] fifo_level,
  input  logic                 fifo_full,
  output logic                 fifo_r_e,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic [2:0]           wb_cti_o,
  input  logic                 wb_ack_i,
  output logic                 buf_sel,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int C_WORDS = p_WIDTH * p_HEIGHT / 4;
  localparam int WCNT_W  = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
  localparam int BEAT_W  = (p_BURST > 1) ? $clog2(p_BURST) : 1;

  localparam logic [WCNT_W-1:0]    C_LAST_WORD = WCNT_W'(C_WORDS - 1);
  localparam logic [BEAT_W-1:0]    C_LAST_BEAT = BEAT_W'(p_BURST - 1);
  localparam logic [p_LEVEL_W-1:0] C_BURST_LVL = p_LEVEL_W'(p_BURST);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]         adr_q, adr_d;
  logic                buf_sel_q, buf_sel_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [2:0]          cti_q, cti_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;

  logic                beat;
  logic                last_beat;
  logic                frame_end;

  assign beat      = cyc_q & wb_ack_i;
  assign last_beat = beat & (beat_cnt_q == C_LAST_BEAT);
  assign frame_end = last_beat & (word_cnt_q == C_LAST_WORD);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q      <= OFF;
      word_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      adr_q        <= '0;
      buf_sel_q    <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'h0;
      cti_q        <= CTI_CLASSIC;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      adr_q        <= adr_d;
      buf_sel_q    <= buf_sel_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      cti_q        <= cti_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (enable) state_d = WAIT;
      WAIT:    if (fifo_level >= C_BURST_LVL) state_d = BURST;
      BURST:   if (last_beat) state_d = frame_end ? FEND : WAIT;
      FEND:    state_d = enable ? WAIT : OFF;
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    adr_d      = adr_q;
    buf_sel_d  = buf_sel_q;
    overflow_d = overflow_q | (fifo_full & (state_q != OFF));

    case (state_q)
      OFF: begin
        if (enable) begin
          word_cnt_d = '0;
          beat_cnt_d = '0;
          adr_d      = pick_base(buf_sel_q, base_addr0, base_addr1);
        end
      end
      BURST: begin
        if (beat) begin
          adr_d      = adr_q + 32'd4;
          word_cnt_d = word_cnt_q + 1'b1;
          beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end
        // Toggle on the final ack so buf_sel moves together with frame_done.
        if (frame_end) buf_sel_d = ~buf_sel_q;
      end
      FEND: begin
        word_cnt_d = '0;
        beat_cnt_d = '0;
        adr_d      = pick_base(buf_sel_q, base_addr0, base_addr1);
      end
      default: ;
    endcase

    cyc_d        = (state_d == BURST);
    we_d         = cyc_d;
    sel_d        = cyc_d ? 4'hF : 4'h0;
    cti_d        = !cyc_d ? CTI_CLASSIC : (beat_cnt_d == C_LAST_BEAT) ? CTI_END : CTI_INCR;
    frame_done_d = (state_d == FEND);
  end

  assign fifo_r_e   = wb_stb_o & wb_ack_i;
  assign wb_dat_o   = fifo_data;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_sel_o   = sel_q;
  assign wb_cti_o   = cti_q;
  assign buf_sel    = buf_sel_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_video_in_store.sv
`default_nettype none
// tb_video_in_store: FIFO/Wishbone-slave model with a scoreboard of expected bus beats.
module tb_video_in_store;
  import video_in_pkg::*;

  localparam int W = 64;
  localparam int H = 16;
  localparam int BL = 8;
  localparam int LW = 6;
  localparam int NWORDS = W * H / 4;
  localparam logic [31:0] BASE0 = 32'h0000_1000;
  localparam logic [31:0] BASE1 = 32'h0008_0000;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic enable = 1'b0;
  logic [31:0] base_addr0 = BASE0;
  logic [31:0] base_addr1 = BASE1;
  logic [31:0] fifo_data = '0;
  logic [LW-1:0] fifo_level = '0;
  logic fifo_full = 1'b0;
  logic fifo_r_e;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  logic [2:0] wb_cti_o;
  logic wb_ack_i = 1'b0;
  logic buf_sel, frame_done, overflow;

  always #5 clk = ~clk;

  video_in_store #(.p_WIDTH(W), .p_HEIGHT(H), .p_BURST(BL), .p_LEVEL_W(LW)) dut (
    .clk(clk), .nRST(nRST), .enable(enable),
    .base_addr0(base_addr0), .base_addr1(base_addr1),
    .fifo_data(fifo_data), .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_r_e(fifo_r_e),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
    .buf_sel(buf_sel), .frame_done(frame_done), .overflow(overflow)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fifo_m[$];
  int n_tests = 0;
  int n_fail = 0;
  int push_req = 0;
  int push_done = 0;
  int pop_cnt = 0;
  int ack_pct = 100;
  int stall_beat = -1;
  int stall_cnt = 0;
  int bib = 0;
  bit idle_mode = 1'b0;
  int m_w = 0;
  bit m_buf = 1'b0;
  int mon_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Capture FIFO and Wishbone slave; every word entering the FIFO gets its expected beat.
  initial begin : model
    bit r;
    logic [31:0] d;
    logic [31:0] t;
    beat_t e;
    forever begin
      @(negedge clk);
      r = fifo_r_e & nRST;
      @(posedge clk);
      #1;
      if (!nRST) begin
        fifo_m.delete();
        exp_q.delete();
        m_w = 0;
        m_buf = 1'b0;
        push_done = push_req;
        wb_ack_i = 1'b0;
        bib = 0;
        stall_cnt = 0;
      end else begin
        if (r) begin
          if (fifo_m.size() > 0) t = fifo_m.pop_front();
          pop_cnt++;
          bib++;
        end
        if (!wb_cyc_o) begin
          bib = 0;
          stall_cnt = 0;
        end
        if (push_done < push_req && fifo_m.size() < 60) begin
          d = $urandom;
          fifo_m.push_back(d);
          if (!idle_mode) begin
            e.adr = (m_buf ? BASE1 : BASE0) + 32'(4 * m_w);
            e.dat = d;
            e.cti = ((m_w % BL) == BL - 1) ? 3'b111 : 3'b010;
            exp_q.push_back(e);
            m_w++;
            if (m_w == NWORDS) begin
              m_w = 0;
              m_buf = ~m_buf;
            end
          end
          push_done++;
        end
        if (wb_cyc_o && stall_beat == bib && stall_cnt < 2) begin
          wb_ack_i = 1'b0;
          stall_cnt++;
        end else begin
          wb_ack_i = wb_cyc_o && ($urandom_range(99) < ack_pct);
        end
      end
      fifo_level = LW'(fifo_m.size());
      fifo_data = (fifo_m.size() > 0) ? fifo_m[0] : 32'h0;
    end
  end

  initial begin : monitor
    int beats;
    bit prev_final, prev_end;
    beat_t e;
    beats = 0;
    prev_final = 1'b0;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      if (!nRST) begin
        beats = 0;
        mon_frames = 0;
        prev_final = 1'b0;
        prev_end = 1'b0;
      end else begin
        if (prev_final) chk("frame_done_after_last_ack", 32'(frame_done), 32'd1);
        else if (frame_done) chk("frame_done_unexpected", 32'(frame_done), 32'd0);
        if (frame_done) begin
          mon_frames++;
          chk("buf_sel_at_frame_done", 32'(buf_sel), 32'(mon_frames % 2));
        end
        if (prev_end) chk("cyc_drop_after_burst", 32'(wb_cyc_o), 32'd0);
        prev_final = 1'b0;
        prev_end = 1'b0;
        if (wb_cyc_o) begin
          chk("stb_eq_cyc", 32'(wb_stb_o), 32'd1);
          chk("fifo_r_e", 32'(fifo_r_e), 32'(wb_stb_o & wb_ack_i));
        end
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_adr", wb_adr_o, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_adr", wb_adr_o, e.adr);
            chk("beat_dat", wb_dat_o, e.dat);
            chk("beat_cti", 32'(wb_cti_o), 32'(e.cti));
            chk("beat_we_sel", {27'd0, wb_we_o, wb_sel_o}, {27'd0, 1'b1, 4'hF});
            prev_end = (e.cti == 3'b111);
          end
          beats++;
          prev_final = ((beats % NWORDS) == 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || push_done != push_req) && k < max) begin
      tick(1);
      k++;
    end
    chk(name, 32'(k < max), 32'd1);
    tick(3);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, j, p0, c, target;
    tick(3);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb_we", {30'd0, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel_cti", {25'd0, wb_sel_o, wb_cti_o}, 32'd0);
    chk("rst_flags", {29'd0, buf_sel, frame_done, overflow}, 32'd0);
    chk("rst_fifo_r_e", 32'(fifo_r_e), 32'd0);

    nRST = 1'b1;
    fifo_full = 1'b1;
    tick(1);
    fifo_full = 1'b0;
    tick(1);
    chk("overflow_ignored_in_off", 32'(overflow), 32'd0);

    // Level below burst length: no bus activity, burst starts one cycle after level hits 8.
    enable = 1'b1;
    push_req += 7;
    tick(10);
    chk("level_7", 32'(fifo_level), 32'd7);
    k = 0;
    repeat (50) begin
      tick(1);
      if (wb_cyc_o) k++;
    end
    chk("low_level_no_cyc", 32'(k), 32'd0);
    push_req += 1;
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (fifo_level != LW'(8) && j < 20);
    chk("level_reaches_8", 32'(j < 20), 32'd1);
    chk("burst_entry_pre", 32'(wb_cyc_o), 32'd0);
    @(negedge clk);
    chk("burst_entry", 32'(wb_cyc_o), 32'd1);
    wait_drain("drain_first_burst", 100);

    // Two-cycle ack stall in the middle of a burst.
    stall_beat = 3;
    p0 = pop_cnt;
    push_req += 8;
    wait_drain("drain_stall_burst", 200);
    chk("stall_pops", 32'(pop_cnt - p0), 32'd8);
    stall_beat = -1;

    // Random acks and bursty producer across three frames.
    ack_pct = 70;
    target = 3 * NWORDS;
    while (push_req < target) begin
      c = $urandom_range(1, 20);
      if (push_req + c > target) c = target - push_req;
      push_req += c;
      tick($urandom_range(0, 15));
    end
    wait_drain("drain_three_frames", 20000);
    chk("frames_3", 32'(mon_frames), 32'd3);
    chk("buf_sel_after_3", 32'(buf_sel), 32'd1);

    // Enable dropped mid-frame: frame completes, then no further cycles.
    push_req += 104;
    wait_drain("drain_to_word_104", 2000);
    enable = 1'b0;
    push_req += NWORDS - 104;
    wait_drain("drain_enable_off_frame", 4000);
    chk("frames_4", 32'(mon_frames), 32'd4);
    chk("buf_sel_after_4", 32'(buf_sel), 32'd0);
    idle_mode = 1'b1;
    push_req += 8;
    k = 0;
    repeat (40) begin
      tick(1);
      if (wb_cyc_o) k++;
    end
    chk("off_no_bus", 32'(k), 32'd0);

    // Reset, one frame into buffer 0, then reset in the middle of a buffer-1 burst.
    nRST = 1'b0;
    tick(1);
    idle_mode = 1'b0;
    enable = 1'b1;
    ack_pct = 100;
    nRST = 1'b1;
    push_req += NWORDS;
    wait_drain("drain_frame_after_rst", 4000);
    chk("buf_sel_before_mid_rst", 32'(buf_sel), 32'd1);
    push_req += 16;
    j = 0;
    while (bib < 4 && j < 200) begin
      tick(1);
      j++;
    end
    chk("reach_beat_4", 32'(j < 200), 32'd1);
    nRST = 1'b0;
    tick(1);
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_buf_sel", 32'(buf_sel), 32'd0);
    chk("mid_rst_no_frame_done", 32'(frame_done), 32'd0);
    nRST = 1'b1;

    // Restart at base0, with fifo_full coinciding with the last ack.
    push_req += 8;
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!(wb_cyc_o && wb_cti_o == 3'b111 && wb_ack_i) && j < 200);
    chk("reach_last_beat", 32'(j < 200), 32'd1);
    fifo_full = 1'b1;
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    chk("overflow_set", 32'(overflow), 32'd1);
    wait_drain("drain_restart_burst", 200);
    tick(20);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    nRST = 1'b0;
    tick(1);
    chk("overflow_cleared_by_rst", 32'(overflow), 32'd0);
    nRST = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_in_store.md
# video_in_store

Frame-store controller for the video input path. It drains the 32-bit pixel-word FIFO, which is filled by the capture stage at 4 pixels per word, and writes the words to memory as fixed-length Wishbone incrementing bursts. It also sequences frame-buffer addresses, ping-ponging between two base addresses, and reports frame completion and FIFO overflow. It sits between the capture FIFO read port and the system Wishbone interconnect, and runs entirely in the 100 MHz system domain.

## Interface
Parameters:
- p_WIDTH, 640, pixels per line
- p_HEIGHT, 480, lines per frame
- p_BURST, 8, words per Wishbone burst; p_WIDTH*p_HEIGHT/4 must be a multiple of p_BURST
- p_LEVEL_W, 6, width of the FIFO fill-level input

Ports:
- clk  in  1  system clock, 100 MHz
- nRST  in  1  reset, synchronous, active-low (sampled on posedge clk)
- enable  in  1  capture enable; only sampled at frame boundaries
- base_addr0  in  32  byte address of buffer 0; 4-byte aligned
- base_addr1  in  32  byte address of buffer 1; 4-byte aligned
- fifo_data  in  32  show-ahead FIFO head word; valid while fifo_empty=0
- fifo_level  in  p_LEVEL_W  words currently in the FIFO
- fifo_full  in  1  FIFO full flag
- fifo_r_e  out  1  pop strobe
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master control
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select
- wb_cti_o  out  3  cycle type identifier
- wb_ack_i  in  1  Wishbone acknowledge
- buf_sel  out  1  buffer currently being written
- frame_done  out  1  one-cycle pulse after the last word of a frame is acked
- overflow  out  1  sticky flag: fifo_full seen while active

## Operation
- Constants:
  - WORDS = p_WIDTH*p_HEIGHT/4 (76800)
  - BURSTS = WORDS/p_BURST
- Counters:
  - word_cnt: 17 bits, 0..WORDS-1
  - beat_cnt: $clog2(p_BURST) bits
- States:
  - OFF: idle. Go to WAIT when enable=1; at that transition word_cnt=0 and the address is taken from the base of buf_sel.
  - WAIT: go to BURST when fifo_level >= p_BURST.
  - BURST: Wishbone cycle open.
    - Each cycle with wb_ack_i=1 is one beat. On each beat:
      - pop the FIFO (fifo_r_e = wb_stb_o & wb_ack_i, combinational);
      - add 4 to the address;
      - increment beat_cnt and word_cnt.
    - On the last beat of a burst:
      - if word_cnt != WORDS-1, go to WAIT;
      - otherwise go to FEND.
  - FEND: for one cycle:
    - pulse frame_done;
    - toggle buf_sel;
    - clear word_cnt;
    - load the address from the base of the new buf_sel;
    - then go to WAIT if enable=1, else OFF.
- Bus fields during BURST:
  - wb_we_o=1, wb_sel_o=4'hF.
  - wb_cti_o=3'b010 on every beat except the last, which uses 3'b111.
  - wb_dat_o = fifo_data (pass-through).
  - wb_adr_o = base + 4*word_cnt.
- Outside BURST: wb_cyc_o=wb_stb_o=0, wb_cti_o=0.
- Enable deasserted mid-frame has no effect; the current frame completes.
- The base inputs are sampled only on entry to a frame (OFF→WAIT, FEND).
- overflow:
  - set when fifo_full=1 in any state other than OFF;
  - cleared only by reset.
- Reset values: every output 0, state OFF, buf_sel 0, counters 0.

## Timing
- All outputs are registered, except fifo_r_e and wb_dat_o.
- Burst entry: WAIT→BURST takes one cycle, so wb_cyc_o/wb_stb_o rise the cycle after fifo_level reaches p_BURST.
- With zero-wait acks, a burst occupies p_BURST cycles. wb_cyc_o/wb_stb_o fall on the cycle after the last ack.
- Wait states: while wb_ack_i=0, the address, cti and data are held. No beat is counted and no pop occurs.
- frame_done is high in the cycle after the final ack. buf_sel changes in the same cycle.
- Reset asserted mid-burst:
  - the cycle is dropped at the next edge (wb_cyc_o=0);
  - the partial frame is abandoned;
  - no frame_done is issued.
- Simultaneous last ack and fifo_full: both are processed; the beat completes and overflow is set.

## Structure
- Package video_in_pkg holds:
  - the state enum (OFF, WAIT, BURST, FEND);
  - the WORDS/BURSTS constants;
  - the Wishbone CTI localparams (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111).
- Single module; no sub-module needed.
- The address generator stays inline: a base register plus a 4-byte incrementer.

## Test plan
- Single burst:
  - stimulus: enable=1, base_addr0=0x1000, fifo_level=8, zero-wait acks;
  - response: 8 beats at addresses 0x1000..0x101C; cti 010×7 then 111; 8 pops; returns to WAIT.
- Wait states:
  - stimulus: ack held low 2 cycles on beat 3;
  - response: adr/dat held; no extra pop; total 8 pops.
- Low level:
  - stimulus: fifo_level=7 for 50 cycles;
  - response: wb_cyc_o stays 0; burst starts one cycle after level becomes 8.
- Full frame:
  - stimulus: 9600 bursts;
  - response:
    - last address is base_addr0+0x4AFFC;
    - frame_done pulses once;
    - buf_sel becomes 1;
    - the next burst starts at base_addr1.
- Enable dropped at word 100:
  - response: the frame completes; after FEND the state is OFF and there are no further bus cycles.
- Reset mid-burst, then overflow:
  - stimulus: nRST=0 at beat 4, then released; later fifo_full=1 for one cycle;
  - response:
    - after reset: wb_cyc_o=0 and buf_sel=0;
    - a later enable restarts at base_addr0;
    - overflow=1 stays set until the next reset.
